sweep_decoder: RTL

//  Receive-side checker for the road-sign LED sweep bus. Samples a 4-bit LED pattern on

---
 rtl/sweep_decoder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sweep_decoder.sv
// rtl/sweep_decoder.sv - LED sweep bus receive checker: direction, sweep count, lock, errors
module sweep_decoder #(
  parameter int CNT_W       = 8,
  parameter int LOCK_SWEEPS = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             tick,
  input  logic             clr,
  input  logic [3:0]       led_in,
  output logic [1:0]       dir,
  output logic             locked,
  output logic             sweep_done,
  output logic             err,
  output logic [CNT_W-1:0] sweep_count
);

  localparam int LK_W = (LOCK_SWEEPS < 1) ? 1 : $clog2(LOCK_SWEEPS + 1);
  localparam logic [LK_W-1:0] LOCK_MAX = LK_W'(LOCK_SWEEPS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    TRACK_L = 2'd2,
    TRACK_R = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LK_W-1:0]   lock_q, lock_d;
  logic              locked_q, locked_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        dir_q, dir_d;
  logic [2:0]        next_idx;
  logic [3:0]        expected;

  // Pattern at position i of the left sweep, or of its mirror for the right sweep.
  function automatic logic [3:0] seq_val(input logic right, input logic [2:0] i);
    logic [3:0] v;
    case (i)
      3'd1:    v = 4'b0001;
      3'd2:    v = 4'b0011;
      3'd3:    v = 4'b0110;
      3'd4:    v = 4'b1100;
      3'd5:    v = 4'b1000;
      default: v = 4'b0000;
    endcase
    return right ? {v[0], v[1], v[2], v[3]} : v;
  endfunction

  // Next-state logic: one decision per qualified sample; clr overrides everything.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    lock_d   = lock_q;
    locked_d = locked_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    next_idx = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    expected = seq_val(state_q == TRACK_R, next_idx);

    if (clr) begin
      state_d  = IDLE;
      idx_d    = 3'd0;
      cnt_d    = '0;
      lock_d   = '0;
      locked_d = 1'b0;
    end else if (enable && tick) begin
      case (state_q)
        IDLE: begin
          if (led_in == 4'b0000) state_d = SYNC;
        end
        SYNC: begin
          if (led_in == 4'b0001) begin
            state_d = TRACK_L;
            idx_d   = 3'd1;
          end else if (led_in == 4'b1000) begin
            state_d = TRACK_R;
            idx_d   = 3'd1;
          end else if (led_in != 4'b0000) begin
            err_d   = 1'b1;
            state_d = IDLE;
            idx_d   = 3'd0;
          end
        end
        default: begin
          if (led_in == expected) begin
            idx_d = next_idx;
            if (next_idx == 3'd0) begin
              done_d = 1'b1;
              if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
              if (lock_q != LOCK_MAX) lock_d = lock_q + LK_W'(1);
              if (lock_d >= LOCK_MAX) locked_d = 1'b1;
            end
          end else begin
            err_d    = 1'b1;
            lock_d   = '0;
            locked_d = 1'b0;
            idx_d    = 3'd0;
            state_d  = (led_in == 4'b0000) ? SYNC : IDLE;
          end
        end
      endcase
    end

    case (state_d)
      TRACK_L: dir_d = 2'b01;
      TRACK_R: dir_d = 2'b10;
      default: dir_d = 2'b00;
    endcase
  end

  // State and output registers; everything visible on the edge that captures the sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= 3'd0;
      cnt_q    <= '0;
      lock_q   <= '0;
      locked_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      dir_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      lock_q   <= lock_d;
      locked_q <= locked_d;
      done_q   <= done_d;
      err_q    <= err_d;
      dir_q    <= dir_d;
    end
  end

  assign dir         = dir_q;
  assign locked      = locked_q;
  assign sweep_done  = done_q;
  assign err         = err_q;
  assign sweep_count = cnt_q;

endmodule
